// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the row-multiplexed LED matrix scanner.
//   scan_state_e : scan FSM states (ST_BLANK = all rows off, ST_DRIVE = one row on)
//   ROW_OFF      : level of a row select line when the row is not driven
//   row_level    : one-cold decode of a single row select line
//   max_u        : larger of two unsigned values, for sizing counters
package led_matrix_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Row selects are active-low; an idle line sits high.
    localparam logic ROW_OFF = 1'b1;

    // Level of row select line 'row' when 'row_idx' is the driven row.
    function automatic logic row_level(input int unsigned row_idx, input int unsigned row);
        return (row == row_idx) ? ~ROW_OFF : ROW_OFF;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell/blank interval timer for the matrix scanner.
// Counts the cycles spent in the current scan state from 0 up to 'last' and raises the
// terminal-count pulse on the final cycle, restarting at 0 on the following edge so the
// next state always begins with a fresh count.
//   clk       : system clock
//   aclr      : asynchronous reset, active-high (count returns to 0)
//   last      : index of the final cycle of the current interval (length - 1)
//   on_cycles : number of leading cycles of an interval in which columns may be lit
//   tc        : terminal count, high on the last cycle of the interval
//   on_next   : the count the next cycle will hold is still inside the lit window
module scan_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic [CNT_W-1:0] last,
    input  logic [CNT_W-1:0] on_cycles,
    output logic             tc,
    output logic             on_next
);

    logic [CNT_W-1:0] count_q, count_d;

    assign tc      = (count_q == last);
    assign count_d = tc ? '0 : count_q + CNT_W'(1);
    // Looks one cycle ahead because the column outputs are registered.
    assign on_next = (count_d < on_cycles);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with anti-ghosting blanking and a double-buffered frame.
// Each row is driven for DWELL cycles, preceded by BLANK cycles with every row off.
// A new frame is parked in a shadow buffer and copied to the display buffer only when the
// scan enters the blanking interval ahead of row 0, so a frame is never shown half-updated.
// Optional feature macro: LED_BRIGHTNESS_EN adds the 'brightness' port and PWM-style duty
// control of the columns within each dwell.
//   clk         : system clock, all logic on posedge
//   aclr        : asynchronous reset, active-high
//   frame_in    : ROWS*COLS image, row r = frame_in[r*COLS +: COLS], 1 = lit
//   frame_valid : frame_in valid this cycle
//   frame_ready : shadow buffer empty; frame taken when valid & ready
//   brightness  : duty level, sampled at the start of each row (LED_BRIGHTNESS_EN only)
//   matrix_row  : one-cold row select, 0 = row driven, registered
//   matrix_col  : column data for the driven row, 1 = lit, registered
//   frame_start : one-cycle pulse on the first driven cycle of row 0
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 16,
    parameter int unsigned DWELL    = 1024,
    parameter int unsigned BLANK    = 16,
    parameter int unsigned BRIGHT_W = 4
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic [ROWS*COLS-1:0] frame_in,
    input  logic                 frame_valid,
    output logic                 frame_ready,
`ifdef LED_BRIGHTNESS_EN
    input  logic [BRIGHT_W-1:0]  brightness,
`endif
    output logic [ROWS-1:0]      matrix_row,
    output logic [COLS-1:0]      matrix_col,
    output logic                 frame_start
);

    localparam int unsigned CNT_W = $clog2(max_u(DWELL, BLANK) + 1);
    localparam int unsigned ROW_W = $clog2(ROWS);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DWELL - 1);
    // With no blanking the reset-time BLANK state lasts a single cycle.
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK == 0) ? '0 : CNT_W'(BLANK - 1);

    if (ROWS < 2 || COLS < 1 || DWELL < 1 || BRIGHT_W < 1) begin : g_bad_params
        $error("led_matrix_scanner: illegal parameter set");
    end

    scan_state_e          state_q, state_d;
    logic [ROW_W-1:0]     row_idx_q, row_idx_d;
    logic [ROWS*COLS-1:0] display_q, display_d;
    logic [ROWS*COLS-1:0] shadow_q, shadow_d;
    logic                 shadow_full_q, shadow_full_d;

    logic [ROWS-1:0]      row_d;
    logic [COLS-1:0]      col_d;
    logic                 frame_start_d;

    logic [CNT_W-1:0]     timer_last;
    logic [CNT_W-1:0]     on_cycles_d;
    logic                 tc;
    logic                 on_next;
    logic                 last_row;
    logic                 accept;
    logic                 swap;
    logic                 drive_entry;

    assign timer_last = (state_q == ST_DRIVE) ? DRIVE_LAST : BLANK_LAST;

    scan_timer #(
        .CNT_W (CNT_W)
    ) u_scan_timer (
        .clk       (clk),
        .aclr      (aclr),
        .last      (timer_last),
        .on_cycles (on_cycles_d),
        .tc        (tc),
        .on_next   (on_next)
    );

    assign last_row    = (row_idx_q == ROW_W'(ROWS - 1));
    assign frame_ready = ~shadow_full_q;
    assign accept      = frame_valid & ~shadow_full_q;
    // Leaving the last row is the moment the scan enters the blanking ahead of row 0.
    // accept needs an empty shadow and swap a full one, so they never coincide.
    assign swap        = (state_q == ST_DRIVE) & tc & last_row & shadow_full_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q   <= ST_BLANK;
            row_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        case (state_q)
            ST_BLANK: begin
                if (tc) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (tc) begin
                    state_d   = (BLANK == 0) ? ST_DRIVE : ST_BLANK;
                    row_idx_d = last_row ? '0 : row_idx_q + ROW_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    assign drive_entry = (state_d == ST_DRIVE) & ((state_q == ST_BLANK) | tc);

    // ---------------- Frame buffers ----------------
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        display_d     = display_q;
        if (accept) begin
            shadow_d      = frame_in;
            shadow_full_d = 1'b1;
        end else if (swap) begin
            display_d     = shadow_q;
            shadow_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            display_q     <= '0;
        end else begin
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            display_q     <= display_d;
        end
    end

    // ---------------- Brightness ----------------
`ifdef LED_BRIGHTNESS_EN
    localparam int unsigned PROD_W = BRIGHT_W + 1 + CNT_W;

    logic [CNT_W-1:0]  on_cycles_q;
    logic [PROD_W-1:0] on_calc;

    // Full-scale brightness gives exactly DWELL lit cycles.
    assign on_calc     = ((PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(DWELL)) >> BRIGHT_W;
    assign on_cycles_d = drive_entry ? CNT_W'(on_calc) : on_cycles_q;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            on_cycles_q <= '0;
        end else begin
            on_cycles_q <= on_cycles_d;
        end
    end
`else
    assign on_cycles_d = CNT_W'(DWELL);
`endif

    // ---------------- FSM: outputs ----------------
    // Computed from the next state so the registered pins line up with state_q.
    always_comb begin
        row_d         = {ROWS{ROW_OFF}};
        col_d         = '0;
        frame_start_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            for (int r = 0; r < ROWS; r++) begin
                row_d[r] = row_level(32'(row_idx_d), unsigned'(r));
            end
            if (on_next) begin
                col_d = display_d[row_idx_d * COLS +: COLS];
            end
            frame_start_d = drive_entry & (row_idx_d == '0);
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            matrix_row  <= {ROWS{ROW_OFF}};
            matrix_col  <= '0;
            frame_start <= 1'b0;
        end else begin
            matrix_row  <= row_d;
            matrix_col  <= col_d;
            frame_start <= frame_start_d;
        end
    end

endmodule
